// File: rtl/reg_file_bank_sb.sv
// reg_file_bank_sb: multithreaded register file with one bank of 2^ADDR_WIDTH
// registers per thread. It has two combinational read ports, one write port,
// a per-thread pending-write scoreboard and a multi-cycle thread-clear
// sequencer. Register 0 of every thread always reads as zero.
//
// Build option: define REG_FILE_BYPASS_EN for write-first read bypass. With the
// bypass, a read of the register being written returns the incoming data in
// the same cycle. A read of the register being cleared returns zero.
module reg_file_bank_sb #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 4,
    parameter int TH_ID_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    // read ports
    input  logic [TH_ID_WIDTH-1:0] rd_th_id,
    input  logic [ADDR_WIDTH-1:0]  r0addr,
    input  logic [ADDR_WIDTH-1:0]  r1addr,
    output logic [DATA_WIDTH-1:0]  r0data,
    output logic [DATA_WIDTH-1:0]  r1data,
    output logic                   r0busy,
    output logic                   r1busy,
    // write port
    input  logic                   wena,
    input  logic [TH_ID_WIDTH-1:0] w_th_id,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    output logic                   wr_ready,
    // scoreboard set (issue side)
    input  logic                   sb_set,
    input  logic [TH_ID_WIDTH-1:0] sb_th_id,
    input  logic [ADDR_WIDTH-1:0]  sb_addr,
    // thread clear
    input  logic                   clr_req,
    input  logic [TH_ID_WIDTH-1:0] clr_th_id,
    output logic                   clr_busy,
    output logic                   clr_done
);

    localparam int NUM_REGS    = 1 << ADDR_WIDTH;
    localparam int NUM_THREADS = 1 << TH_ID_WIDTH;
    localparam int MEM_DEPTH   = NUM_REGS * NUM_THREADS;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } clr_state_e;

    clr_state_e                              state_q, state_d;
    logic [TH_ID_WIDTH-1:0]                  clr_th_q, clr_th_d;
    logic [ADDR_WIDTH-1:0]                   clr_cnt_q, clr_cnt_d;
    logic [NUM_THREADS-1:0][NUM_REGS-1:0]    sb_q, sb_d;
    logic [DATA_WIDTH-1:0]                   mem_q [MEM_DEPTH];

    logic                                    clear_active;
    logic                                    write_fire;
    logic                                    sb_set_ok;
    logic                                    mem_we;
    logic [TH_ID_WIDTH+ADDR_WIDTH-1:0]       mem_waddr;
    logic [DATA_WIDTH-1:0]                   mem_wdata;

    // The clear sequencer owns the single write port while it runs.
    assign clear_active = (state_q == ST_CLEAR);
    assign wr_ready     = !clear_active;
    assign clr_busy     = clear_active;
    assign clr_done     = (state_q == ST_DONE);
    assign write_fire   = wena && wr_ready && (waddr != '0);

    // Clear sequencer next-state: latch the thread, sweep addresses 1..last.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch.
        state_d   = state_q;
        clr_th_d  = clr_th_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    clr_th_d  = clr_th_id;
                    clr_cnt_d = ADDR_WIDTH'(1);
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clear sequencer state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q   <= ST_IDLE;
            clr_th_q  <= '0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_th_q  <= clr_th_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Scoreboard next-state. A new producer (set) beats a retiring write.
    // During a clear, a set to an address still ahead of the sweep loses,
    // because the sweep will zero that bit anyway.
    always_comb begin
        sb_d      = sb_q;
        sb_set_ok = sb_set && (sb_addr != '0) &&
                    !(clear_active && (sb_th_id == clr_th_q) && (sb_addr >= clr_cnt_q));
        if (write_fire) begin
            sb_d[w_th_id][waddr] = 1'b0;
        end
        if (clear_active) begin
            sb_d[clr_th_q][clr_cnt_q] = 1'b0;
        end
        if (sb_set_ok) begin
            sb_d[sb_th_id][sb_addr] = 1'b1;
        end
    end

    // Scoreboard register. All pending bits drop on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // Single write port shared by the pipeline and the clear sweep.
    assign mem_we    = write_fire || clear_active;
    assign mem_waddr = clear_active ? {clr_th_q, clr_cnt_q} : {w_th_id, waddr};
    assign mem_wdata = clear_active ? '0 : wdata;

    // Register storage. The sweep still commits its write on a reset edge,
    // so registers already zeroed stay zero.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; only the clear sequencer zeroes a bank.
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read port 0: address 0 is hardwired to zero and never busy.
    always_comb begin
        r0data = '0;
        r0busy = 1'b0;
        if (r0addr != '0) begin
            r0data = mem_q[{rd_th_id, r0addr}];
            r0busy = sb_q[rd_th_id][r0addr];
`ifdef REG_FILE_BYPASS_EN
            if (write_fire && (w_th_id == rd_th_id) && (waddr == r0addr)) begin
                r0data = wdata;
                r0busy = 1'b0;
            end else if (clear_active && (clr_th_q == rd_th_id) && (clr_cnt_q == r0addr)) begin
                r0data = '0;
            end
`endif
        end
    end

    // Read port 1: identical to port 0.
    always_comb begin
        r1data = '0;
        r1busy = 1'b0;
        if (r1addr != '0) begin
            r1data = mem_q[{rd_th_id, r1addr}];
            r1busy = sb_q[rd_th_id][r1addr];
`ifdef REG_FILE_BYPASS_EN
            if (write_fire && (w_th_id == rd_th_id) && (waddr == r1addr)) begin
                r1data = wdata;
                r1busy = 1'b0;
            end else if (clear_active && (clr_th_q == rd_th_id) && (clr_cnt_q == r1addr)) begin
                r1data = '0;
            end
`endif
        end
    end

endmodule
